// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared constants for the RAM port arbiter slice: default address/data
// widths, the fixed read latency of the RAM port as seen by requesters, and
// the requester-id width helper used to size the grant index and the
// response routing pipeline.
package ram_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned REQUESTERS_DEF = 4;

  // Edges between the command register and the response cycle.
  localparam int unsigned RD_LATENCY = 2;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ID_WIDTH = id_width(REQUESTERS_DEF);

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin grant. The search begins one past the
// last granted requester and wraps, so the previous winner has lowest
// priority.
//   vld        in  N    request valid per requester
//   last_grant in  IDW  index of the most recently accepted requester
//   gnt        out N    one-hot-or-zero grant
//   gnt_idx    out IDW  encoded index of the granted requester (0 if none)
//   gnt_any    out 1    a grant is being issued
module rr_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N   = REQUESTERS_DEF,
  parameter int unsigned IDW = id_width(N)
) (
  input  logic [N-1:0]   vld,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [IDW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sel     = '0;
    // Offsets 1..N visit every requester exactly once, ending on last_grant.
    for (int unsigned k = 1; k <= N; k++) begin
      sel = IDW'((32'(last_grant) + k) % N);
      if (!gnt_any && vld[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one port of an external write-first RAM between REQUESTERS
// requesters. A round-robin arbiter accepts at most one request per cycle,
// the accepted request is registered as the RAM command, and a two-stage
// id pipeline routes read data back to the requester that issued it.
//   clk, rst             clock, asynchronous active-high reset
//   req_vld/req_we       per-requester valid and write(1)/read(0)
//   req_addr/req_din     packed per-requester address and write data
//   req_rdy              one-hot-or-zero grant (combinational)
//   resp_vld             one-hot-or-zero read-data valid
//   resp_dout            read data, shared, qualified by resp_vld
//   ram_addr/din/en/we   registered RAM command
//   ram_dout             RAM read data, valid one cycle after sampling
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned REQUESTERS = REQUESTERS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTERS-1:0]            req_vld,
  input  logic [REQUESTERS-1:0]            req_we,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_din,
  output logic [REQUESTERS-1:0]            req_rdy,
  output logic [REQUESTERS-1:0]            resp_vld,
  output logic [DATA_WIDTH-1:0]            resp_dout,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_din,
  output logic                             ram_en,
  output logic                             ram_we,
  input  logic [DATA_WIDTH-1:0]            ram_dout
);

  localparam int unsigned IDW = id_width(REQUESTERS);

  logic [ADDR_WIDTH-1:0] addr_arr [REQUESTERS];
  logic [DATA_WIDTH-1:0] din_arr  [REQUESTERS];

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_arr[g]  = req_din[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [REQUESTERS-1:0] gnt;
  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;

  logic [IDW-1:0]        last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [IDW-1:0]        cmd_id_q, cmd_id_d;

  // Read routing pipeline; stage RD_LATENCY-1 lines up with ram_dout.
  logic [RD_LATENCY-1:0]          rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:0][IDW-1:0] rd_id_q, rd_id_d;

  rr_arbiter #(
    .N   (REQUESTERS),
    .IDW (IDW)
  ) u_rr (
    .vld        (req_vld),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // The grant is combinational; masking it keeps req_rdy low throughout an
  // asynchronous reset even though the request inputs may be active.
  always_comb begin
    req_rdy = rst ? '0 : gnt;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    cmd_id_d     = cmd_id_q;
    if (gnt_any) begin
      last_grant_d = gnt_idx;
      ram_addr_d   = addr_arr[gnt_idx];
      ram_din_d    = din_arr[gnt_idx];
      ram_en_d     = 1'b1;
      ram_we_d     = req_we[gnt_idx];
      cmd_id_d     = gnt_idx;
    end
  end

  always_comb begin
    rd_vld_d    = '0;
    rd_id_d     = '0;
    rd_vld_d[0] = ram_en_q & ~ram_we_q;
    rd_id_d[0]  = cmd_id_q;
    for (int unsigned s = 1; s < RD_LATENCY; s++) begin
      rd_vld_d[s] = rd_vld_q[s-1];
      rd_id_d[s]  = rd_id_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDW'(REQUESTERS - 1);
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      cmd_id_q     <= '0;
      rd_vld_q     <= '0;
      rd_id_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      cmd_id_q     <= cmd_id_d;
      rd_vld_q     <= rd_vld_d;
      rd_id_q      <= rd_id_d;
    end
  end

  always_comb begin
    resp_vld = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (rd_vld_q[RD_LATENCY-1] && (32'(rd_id_q[RD_LATENCY-1]) == i)) begin
        resp_vld[i] = 1'b1;
      end
    end
  end

  assign resp_dout = ram_dout;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_vld = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_din = '0;
  logic [NR-1:0]     req_rdy;
  logic [NR-1:0]     resp_vld;
  logic [DW-1:0]     resp_dout;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic              ram_en;
  logic              ram_we;
  logic [DW-1:0]     ram_dout;

  ram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .REQUESTERS (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_din   (req_din),
    .req_rdy   (req_rdy),
    .resp_vld  (resp_vld),
    .resp_dout (resp_dout),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // External write-first RAM port: command sampled on an edge, data
  // presented one cycle later.
  logic [DW-1:0] bram [256];
  logic [DW-1:0] rd_stage = '0;
  initial ram_dout = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        bram[ram_addr] <= ram_din;
        rd_stage       <= ram_din;
      end else begin
        rd_stage <= bram[ram_addr];
      end
    end
    ram_dout <= rd_stage;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  typedef struct {
    int          due;
    int          id;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    int          due;
    bit          en;
    bit          we;
    logic [7:0]  addr;
    logic [63:0] din;
  } cmd_t;

  resp_t rq[$];
  cmd_t  cq[$];

  // Reference model state
  logic [63:0] m_mem [256];
  int          m_lg;
  logic [7:0]  m_last_addr;
  logic [63:0] m_last_din;
  int          wait_cnt [NR];

  logic [7:0]  a_arr [NR];
  logic [63:0] d_arr [NR];

  task automatic model_reset();
    m_lg        = NR - 1;
    m_last_addr = '0;
    m_last_din  = '0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    rq.delete();
    cq.delete();
  endtask

  // Apply one cycle of requests, check the grant against the model, and
  // queue the expected RAM command and read response.
  task automatic drive(input logic [NR-1:0] vld, input logic [NR-1:0] we,
                       output int gidx);
    int          exp_g;
    logic [3:0]  exp_rdy;
    cmd_t        c;
    resp_t       r;
    req_vld = vld;
    req_we  = we;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = a_arr[i];
      req_din[i*DW +: DW]  = d_arr[i];
    end
    #1;
    exp_g = -1;
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (m_lg + k) % NR;
      if (exp_g < 0 && vld[idx]) exp_g = idx;
    end
    exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0000;
    chk(req_rdy == exp_rdy, "grant", 64'(req_rdy), 64'(exp_rdy));
    gidx = -1;
    for (int i = NR - 1; i >= 0; i--) if (req_rdy[i]) gidx = i;
    for (int i = 0; i < NR; i++) begin
      if (req_rdy[i]) begin
        chk(wait_cnt[i] < NR, "starvation", 64'(wait_cnt[i]), 64'(NR - 1));
        wait_cnt[i] = 0;
      end else if (vld[i]) begin
        wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
    end
    c.due = cyc + 1;
    if (exp_g >= 0) begin
      m_lg        = exp_g;
      c.en        = 1'b1;
      c.we        = we[exp_g];
      c.addr      = a_arr[exp_g];
      c.din       = d_arr[exp_g];
      m_last_addr = c.addr;
      m_last_din  = c.din;
      if (we[exp_g]) begin
        m_mem[c.addr] = c.din;
      end else begin
        r.due  = cyc + 3;
        r.id   = exp_g;
        r.data = m_mem[c.addr];
        rq.push_back(r);
      end
    end else begin
      c.en   = 1'b0;
      c.we   = 1'b0;
      c.addr = m_last_addr;
      c.din  = m_last_din;
    end
    cq.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) drive('0, '0, g);
  endtask

  // Monitor: sampled mid-cycle, pops expectations as their cycle arrives.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
          chk(resp_vld == 4'(1 << rq[0].id), "resp_vld", 64'(resp_vld), 64'(1 << rq[0].id));
          chk(resp_dout == rq[0].data, "resp_dout", resp_dout, rq[0].data);
          void'(rq.pop_front());
        end else begin
          chk(resp_vld == '0, "resp_idle", 64'(resp_vld), 64'd0);
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
          chk(ram_en == cq[0].en, "ram_en", 64'(ram_en), 64'(cq[0].en));
          chk(ram_we == cq[0].we, "ram_we", 64'(ram_we), 64'(cq[0].we));
          chk(ram_addr == cq[0].addr, "ram_addr", 64'(ram_addr), 64'(cq[0].addr));
          chk(ram_din == cq[0].din, "ram_din", ram_din, cq[0].din);
          void'(cq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int first3;
    for (int i = 0; i < 256; i++) begin
      bram[i]  = '0;
      m_mem[i] = '0;
    end
    for (int i = 0; i < NR; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    model_reset();

    // Reset state with all requesters asserting.
    rst     = 1'b1;
    req_vld = '1;
    repeat (3) @(posedge clk);
    #1;
    chk(req_rdy == '0, "rst_rdy", 64'(req_rdy), 64'd0);
    chk(resp_vld == '0, "rst_resp_vld", 64'(resp_vld), 64'd0);
    chk(ram_en == 1'b0, "rst_ram_en", 64'(ram_en), 64'd0);
    chk(ram_we == 1'b0, "rst_ram_we", 64'(ram_we), 64'd0);
    chk(ram_addr == '0, "rst_ram_addr", 64'(ram_addr), 64'd0);
    chk(ram_din == '0, "rst_ram_din", ram_din, 64'd0);
    req_vld = '0;
    rst     = 1'b0;
    model_reset();

    // All four reading: grants rotate 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) a_arr[i] = 8'(i + 8 * k);
      drive(4'b1111, 4'b0000, g);
      chk(g == k % NR, "rr_order", 64'(g), 64'(k % NR));
    end
    idle(4);

    // Write from 2 then read from 1 of the same address.
    a_arr[2] = 8'h10;
    d_arr[2] = 64'hDEAD_BEEF;
    drive(4'b0100, 4'b0100, g);
    chk(g == 2, "raw_wr_grant", 64'(g), 64'd2);
    a_arr[1] = 8'h10;
    drive(4'b0010, 4'b0000, g);
    chk(g == 1, "raw_rd_grant", 64'(g), 64'd1);
    chk(m_mem[8'h10] == 64'hDEAD_BEEF, "raw_model", m_mem[8'h10], 64'hDEAD_BEEF);
    idle(4);

    // Requester 3 alone: preload k*3, then back-to-back reads of 0..4.
    for (int k = 0; k < 5; k++) begin
      a_arr[3] = 8'(k);
      d_arr[3] = 64'(k * 3);
      drive(4'b1000, 4'b1000, g);
      chk(g == 3, "solo_wr_grant", 64'(g), 64'd3);
    end
    for (int k = 0; k < 5; k++) begin
      a_arr[3] = 8'(k);
      drive(4'b1000, 4'b0000, g);
      chk(g == 3, "solo_rd_grant", 64'(g), 64'd3);
    end
    idle(4);

    // Requester 0 always valid, requester 3 joins at cycle 5.
    first3 = -1;
    for (int k = 0; k < 12; k++) begin
      a_arr[0] = 8'(k);
      a_arr[3] = 8'(k + 32);
      drive((k >= 5) ? 4'b1001 : 4'b0001, 4'b0000, g);
      if (g == 3 && first3 < 0) first3 = k;
    end
    chk(first3 >= 5 && first3 <= 9, "starve_req3", 64'(first3), 64'd9);
    idle(4);

    // Two reads in flight, then a one-cycle reset.
    a_arr[0] = 8'h10;
    a_arr[1] = 8'h01;
    drive(4'b0001, 4'b0000, g);
    drive(4'b0010, 4'b0000, g);
    rst     = 1'b1;
    req_vld = 4'b1111;
    #1;
    chk(req_rdy == '0, "midrst_rdy", 64'(req_rdy), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk(ram_en == 1'b0, "midrst_ram_en", 64'(ram_en), 64'd0);
    rst = 1'b0;
    idle(5);
    drive(4'b1111, 4'b0000, g);
    chk(g == 0, "post_rst_grant", 64'(g), 64'd0);
    idle(4);

    // Randomized traffic on a small address window to exercise RAW hazards.
    for (int k = 0; k < 400; k++) begin
      logic [NR-1:0] v;
      logic [NR-1:0] w;
      for (int i = 0; i < NR; i++) begin
        a_arr[i] = 8'($urandom_range(0, 15));
        d_arr[i] = {$urandom, $urandom};
      end
      v = NR'($urandom);
      w = NR'($urandom);
      drive(v, w, g);
    end
    idle(6);
    chk(rq.size() == 0, "resp_drain", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
